// File: rtl/accelerator.sv
// rtl/accelerator.sv - byte-stream vector rasterizer emitting one pixel write per clock.
// Optional circle primitive (type 0xE) is enabled by defining ACCEL_CIRCLE_EN.
module accelerator #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   iAWADDR,
    input  logic [2:0]              iAWPROT,
    input  logic                    iAWVALID,
    output logic                    iAWREADY,
    input  logic [DATA_WIDTH-1:0]   iWDATA,
    input  logic [DATA_WIDTH/8-1:0] iWSTRB,
    input  logic                    iWVALID,
    output logic                    iWREADY,
    output logic                    iBVALID,
    input  logic                    iBREADY,
    output logic [1:0]              iBRESP,
    output logic [15:0]             xAddr,
    output logic [15:0]             yAddr,
    output logic                    Write,
    output logic                    RenderEndInterrupt
);
    typedef enum logic [2:0] {S_SYNC0, S_SYNC1, S_ZOOM, S_ANGLE, S_COUNT, S_TYPE, S_ARGS, S_DRAW} state_t;
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
    localparam logic [1:0] K_LINE = 2'd0, K_TRI = 2'd1, K_DOT = 2'd2, K_CIRC = 2'd3;

    state_t state_q, state_d;
    logic ready_q, ready_d, bvalid_q, bvalid_d, irq_q, irq_d, draw_q, draw_d;
    logic [1:0] bresp_q, bresp_d, kind_q, kind_d, edge_q, edge_d;
    logic [7:0] zoom_q, zoom_d, angle_q, angle_d, obj_q, obj_d, byte_w;
    logic [2:0] nargs_q, nargs_d, argi_q, argi_d;
    logic [5:0][7:0] args_q, args_d, args_now;
    logic [2:0][15:0] vx_q, vx_d, vy_q, vy_d, vx_n, vy_n;
    logic [15:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d, end_x_q, end_x_d, end_y_q, end_y_d;
    logic [15:0] px, py, qx, qy;
    logic sxn_q, sxn_d, syn_q, syn_d, accept, fin;
    logic signed [19:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic signed [19:0] ddx, ddy, adx, ady, e2, err_n;
    logic unused_ok;

`ifdef ACCEL_CIRCLE_EN
    logic signed [19:0] ca_q, ca_d, cb_q, cb_d, cd_q, cd_d, ca_n, cb_n;
    logic [2:0] oct_q, oct_d;
    // Octant bits: [0] negates x offset, [1] negates y offset, [2] swaps the offsets.
    function automatic logic [31:0] circ_pix(input logic [15:0] cx, input logic [15:0] cy,
                                             input logic signed [19:0] a, input logic signed [19:0] b,
                                             input logic [2:0] o);
        logic [15:0] u, v;
        u = o[2] ? b[15:0] : a[15:0];
        v = o[2] ? a[15:0] : b[15:0];
        return {o[0] ? cx - u : cx + u, o[1] ? cy - v : cy + v};
    endfunction
`endif

    function automatic logic [15:0] scale(input logic [7:0] b, input logic [7:0] z);
        return {8'd0, b} * {8'd0, z};
    endfunction

    assign byte_w             = iWDATA[7:0];
    assign accept             = ready_q & iAWVALID & iWVALID;
    assign iAWREADY           = ready_q;
    assign iWREADY            = ready_q;
    assign iBVALID            = bvalid_q;
    assign iBRESP             = bresp_q;
    assign xAddr              = cur_x_q;
    assign yAddr              = cur_y_q;
    assign Write              = draw_q;
    assign RenderEndInterrupt = irq_q;
    assign unused_ok          = ^{iAWPROT, iWSTRB, angle_q};

    // Segment setup: new object uses the just-completed argument set, otherwise the next triangle edge.
    always_comb begin
        args_now         = args_q;
        args_now[argi_q] = byte_w;
        vx_n[0] = scale(args_now[0], zoom_q);
        vy_n[0] = scale(args_now[1], zoom_q);
        vx_n[1] = scale(args_now[2], zoom_q);
        vy_n[1] = scale(args_now[3], zoom_q);
        vx_n[2] = scale(args_now[4], zoom_q);
        vy_n[2] = scale(args_now[5], zoom_q);
        if (state_q == S_DRAW) begin
            px = (edge_q == 2'd0) ? vx_q[1] : vx_q[2];
            py = (edge_q == 2'd0) ? vy_q[1] : vy_q[2];
            qx = (edge_q == 2'd0) ? vx_q[2] : vx_q[0];
            qy = (edge_q == 2'd0) ? vy_q[2] : vy_q[0];
        end else begin
            px = vx_n[0];
            py = vy_n[0];
            qx = (kind_q == K_DOT) ? vx_n[0] : vx_n[1];
            qy = (kind_q == K_DOT) ? vy_n[0] : vy_n[1];
        end
        ddx = $signed({4'd0, qx}) - $signed({4'd0, px});
        ddy = $signed({4'd0, qy}) - $signed({4'd0, py});
        adx = (ddx < 0) ? -ddx : ddx;
        ady = (ddy < 0) ? -ddy : ddy;
        e2  = err_q <<< 1;
    end

    always_comb begin
        state_d = state_q;  bvalid_d = bvalid_q;  bresp_d = bresp_q;  draw_d = draw_q;
        kind_d = kind_q;    edge_d = edge_q;      zoom_d = zoom_q;    angle_d = angle_q;
        obj_d = obj_q;      nargs_d = nargs_q;    argi_d = argi_q;    args_d = args_q;
        vx_d = vx_q;        vy_d = vy_q;          cur_x_d = cur_x_q;  cur_y_d = cur_y_q;
        end_x_d = end_x_q;  end_y_d = end_y_q;    sxn_d = sxn_q;      syn_d = syn_q;
        dx_d = dx_q;        dy_d = dy_q;          err_d = err_q;      err_n = err_q;
        irq_d = 1'b0;       fin = 1'b0;
        ready_d = ~ready_q & ~bvalid_q & (state_q != S_DRAW) & iAWVALID & iWVALID;
`ifdef ACCEL_CIRCLE_EN
        ca_d = ca_q;  cb_d = cb_q;  cd_d = cd_q;  oct_d = oct_q;
        cb_n = cb_q + 20'sd1;
        ca_n = (cd_q < 0) ? ca_q : ca_q - 20'sd1;
`endif
        if (bvalid_q && iBREADY) bvalid_d = 1'b0;

        if (accept) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            if (iAWADDR != ADDR_WIDTH'(1)) begin
                bresp_d = RESP_SLVERR;
            end else begin
                case (state_q)
                    S_SYNC0: state_d = (byte_w == 8'h45) ? S_SYNC1 : S_SYNC0;
                    S_SYNC1: state_d = (byte_w == 8'h45) ? S_ZOOM : S_SYNC0;
                    S_ZOOM:  begin zoom_d = (byte_w == 8'd0) ? 8'd1 : byte_w; state_d = S_ANGLE; end
                    S_ANGLE: begin angle_d = byte_w; state_d = S_COUNT; end
                    S_COUNT: begin
                        obj_d   = byte_w;
                        irq_d   = (byte_w == 8'd0);
                        state_d = (byte_w == 8'd0) ? S_SYNC0 : S_TYPE;
                    end
                    S_TYPE: begin
                        argi_d  = 3'd0;
                        state_d = S_ARGS;
                        case (byte_w[3:0])
                            4'h0: state_d = S_TYPE;
                            4'h2: begin kind_d = K_LINE; nargs_d = 3'd4; end
                            4'h7: begin kind_d = K_TRI;  nargs_d = 3'd6; end
                            4'hA: begin kind_d = K_DOT;  nargs_d = 3'd2; end
`ifdef ACCEL_CIRCLE_EN
                            4'hE: begin kind_d = K_CIRC; nargs_d = 3'd3; end
`endif
                            default: begin bresp_d = RESP_SLVERR; state_d = S_SYNC0; end
                        endcase
                    end
                    S_ARGS: begin
                        args_d = args_now;
                        if (argi_q == nargs_q - 3'd1) begin
                            // Response is withheld until the object's last pixel has been written.
                            state_d  = S_DRAW;
                            bvalid_d = 1'b0;
                            draw_d   = 1'b1;
                            edge_d   = 2'd0;
                            vx_d = vx_n;  vy_d = vy_n;
                            cur_x_d = px; cur_y_d = py; end_x_d = qx; end_y_d = qy;
                            sxn_d = ddx < 0; syn_d = ddy < 0;
                            dx_d = adx; dy_d = -ady; err_d = adx - ady;
`ifdef ACCEL_CIRCLE_EN
                            ca_d = $signed({4'd0, vx_n[1]}); cb_d = 20'sd0;
                            cd_d = 20'sd1 - $signed({4'd0, vx_n[1]}); oct_d = 3'd0;
                            if (kind_q == K_CIRC) cur_x_d = vx_n[0] + vx_n[1];
`endif
                        end else begin
                            argi_d = argi_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (state_q == S_DRAW) begin
            if (kind_q == K_CIRC) begin
`ifdef ACCEL_CIRCLE_EN
                if (oct_q != 3'd7) begin
                    oct_d = oct_q + 3'd1;
                    {cur_x_d, cur_y_d} = circ_pix(vx_q[0], vy_q[0], ca_q, cb_q, oct_q + 3'd1);
                end else begin
                    cd_d = (cd_q < 0) ? cd_q + (cb_n <<< 1) + 20'sd1
                                      : cd_q + ((cb_n - ca_n) <<< 1) + 20'sd1;
                    ca_d = ca_n;  cb_d = cb_n;  oct_d = 3'd0;
                    {cur_x_d, cur_y_d} = circ_pix(vx_q[0], vy_q[0], ca_n, cb_n, 3'd0);
                    fin = ca_n < cb_n;
                end
`endif
            end else if (cur_x_q == end_x_q && cur_y_q == end_y_q) begin
                if (edge_q == ((kind_q == K_TRI) ? 2'd2 : 2'd0)) begin
                    fin = 1'b1;
                end else begin
                    edge_d = edge_q + 2'd1;
                    cur_x_d = px; cur_y_d = py; end_x_d = qx; end_y_d = qy;
                    sxn_d = ddx < 0; syn_d = ddy < 0;
                    dx_d = adx; dy_d = -ady; err_d = adx - ady;
                end
            end else begin
                if (e2 >= dy_q) begin
                    err_n   = err_n + dy_q;
                    cur_x_d = sxn_q ? cur_x_q - 16'd1 : cur_x_q + 16'd1;
                end
                if (e2 <= dx_q) begin
                    err_n   = err_n + dx_q;
                    cur_y_d = syn_q ? cur_y_q - 16'd1 : cur_y_q + 16'd1;
                end
                err_d = err_n;
            end
            if (fin) begin
                draw_d   = 1'b0;
                bvalid_d = 1'b1;
                bresp_d  = RESP_OKAY;
                obj_d    = obj_q - 8'd1;
                irq_d    = (obj_q == 8'd1);
                state_d  = (obj_q == 8'd1) ? S_SYNC0 : S_TYPE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_SYNC0;  ready_q <= 1'b0;  bvalid_q <= 1'b0;  bresp_q <= RESP_OKAY;
            irq_q <= 1'b0;       draw_q <= 1'b0;   kind_q <= K_LINE;  edge_q <= 2'd0;
            zoom_q <= 8'd1;      angle_q <= 8'd0;  obj_q <= 8'd0;     nargs_q <= 3'd0;
            argi_q <= 3'd0;      args_q <= '0;     vx_q <= '0;        vy_q <= '0;
            cur_x_q <= 16'd0;    cur_y_q <= 16'd0; end_x_q <= 16'd0;  end_y_q <= 16'd0;
            sxn_q <= 1'b0;       syn_q <= 1'b0;    dx_q <= '0;        dy_q <= '0;
            err_q <= '0;
`ifdef ACCEL_CIRCLE_EN
            ca_q <= '0;  cb_q <= '0;  cd_q <= '0;  oct_q <= 3'd0;
`endif
        end else begin
            state_q <= state_d;  ready_q <= ready_d;  bvalid_q <= bvalid_d;  bresp_q <= bresp_d;
            irq_q <= irq_d;      draw_q <= draw_d;    kind_q <= kind_d;      edge_q <= edge_d;
            zoom_q <= zoom_d;    angle_q <= angle_d;  obj_q <= obj_d;        nargs_q <= nargs_d;
            argi_q <= argi_d;    args_q <= args_d;    vx_q <= vx_d;          vy_q <= vy_d;
            cur_x_q <= cur_x_d;  cur_y_q <= cur_y_d;  end_x_q <= end_x_d;    end_y_q <= end_y_d;
            sxn_q <= sxn_d;      syn_q <= syn_d;      dx_q <= dx_d;          dy_q <= dy_d;
            err_q <= err_d;
`ifdef ACCEL_CIRCLE_EN
            ca_q <= ca_d;  cb_q <= cb_d;  cd_q <= cd_d;  oct_q <= oct_d;
`endif
        end
    end
endmodule

// File: tb/tb_accelerator.sv
// tb/tb_accelerator.sv - directed self-checking bench for the accelerator rasterizer.
module tb_accelerator;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iAWADDR;
    logic [2:0]  iAWPROT;
    logic        iAWVALID, iAWREADY;
    logic [7:0]  iWDATA;
    logic [0:0]  iWSTRB;
    logic        iWVALID, iWREADY, iBVALID, iBREADY;
    logic [1:0]  iBRESP;
    logic [15:0] xAddr, yAddr;
    logic        Write, RenderEndInterrupt;

    always #5 clk = ~clk;

    accelerator dut (
        .clk(clk), .reset(reset), .iAWADDR(iAWADDR), .iAWPROT(iAWPROT),
        .iAWVALID(iAWVALID), .iAWREADY(iAWREADY), .iWDATA(iWDATA), .iWSTRB(iWSTRB),
        .iWVALID(iWVALID), .iWREADY(iWREADY), .iBVALID(iBVALID), .iBREADY(iBREADY),
        .iBRESP(iBRESP), .xAddr(xAddr), .yAddr(yAddr), .Write(Write),
        .RenderEndInterrupt(RenderEndInterrupt)
    );

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int wx[$], wy[$], wc[$], ic[$];
    int hs_cyc, bv_cyc, n_slverr;
    logic [1:0] last_resp;
    logic [7:0] tx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Write) begin
            wx.push_back(int'(xAddr));
            wy.push_back(int'(yAddr));
            wc.push_back(cyc);
        end
        if (RenderEndInterrupt) ic.push_back(cyc);
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wx.delete(); wy.delete(); wc.delete(); ic.delete();
        n_slverr = 0;
    endtask

    task automatic send_byte(input logic [31:0] addr, input logic [7:0] data, input bit wait_resp);
        int t;
        @(negedge clk);
        iAWADDR = addr; iWDATA = data; iAWVALID = 1'b1; iWVALID = 1'b1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!(iAWREADY && iWREADY) && t < 50);
        expect_eq("ready_seen", 32'(iAWREADY & iWREADY), 1);
        @(posedge clk); #1;
        hs_cyc = cyc;
        iAWVALID = 1'b0; iWVALID = 1'b0;
        if (wait_resp) begin
            t = 0;
            while (!iBVALID && t < 1000) begin @(posedge clk); #1; t++; end
            expect_eq("bvalid_seen", 32'(iBVALID), 1);
            bv_cyc = cyc;
            last_resp = iBRESP;
            if (iBRESP != 2'b00) n_slverr++;
            iBREADY = 1'b1;
            @(posedge clk); #1;
            iBREADY = 1'b0;
        end
    endtask

    task automatic send_seq();
        foreach (tx_q[i]) send_byte(32'd1, tx_q[i], 1'b1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; iAWADDR = 0; iAWPROT = 0; iAWVALID = 0; iWDATA = 0;
        iWSTRB = 1'b1; iWVALID = 0; iBREADY = 0;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("reset_ctrl", 32'({iAWREADY, iWREADY, iBVALID, iBRESP, Write, RenderEndInterrupt}), 0);
        expect_eq("reset_addr", {xAddr, yAddr}, 0);
        @(negedge clk) reset = 1'b0;

        // Line + NOP + dot
        clear_log();
        tx_q = '{8'h45, 8'h45, 8'h01, 8'h00, 8'h02, 8'h02, 8'h30, 8'h40, 8'h70, 8'h60,
                 8'h00, 8'h0A, 8'h10, 8'h10};
        send_seq();
        expect_eq("f1_count", wx.size(), 66);
        expect_eq("f1_first", {wx[0][15:0], wy[0][15:0]}, {16'd48, 16'd64});
        expect_eq("f1_mid", {wx[32][15:0], wy[32][15:0]}, {16'd80, 16'd80});
        expect_eq("f1_last", {wx[64][15:0], wy[64][15:0]}, {16'd112, 16'd96});
        expect_eq("f1_span", wc[64] - wc[0], 64);
        expect_eq("f1_dot", {wx[65][15:0], wy[65][15:0]}, {16'd16, 16'd16});
        expect_eq("f1_irqs", ic.size(), 1);
        expect_eq("f1_irq_cyc", ic[0], wc[65] + 1);
        expect_eq("f1_slverr", n_slverr, 0);

        // Zoom 2 horizontal line
        clear_log();
        tx_q = '{8'h45, 8'h45, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00};
        send_seq();
        expect_eq("z2_count", wx.size(), 7);
        for (int i = 0; i < 7; i++) begin
            expect_eq("z2_pix", {wx[i][15:0], wy[i][15:0]}, {16'(i), 16'd0});
            expect_eq("z2_cyc", wc[i], hs_cyc + i);
        end
        expect_eq("z2_bvalid_cyc", bv_cyc, wc[6] + 1);
        expect_eq("z2_irq_cyc", ic[0], wc[6] + 1);

        // Triangle at zoom 1
        clear_log();
        tx_q = '{8'h45, 8'h45, 8'h01, 8'h00, 8'h01, 8'h07, 8'h10, 8'h10, 8'h40, 8'h20, 8'h70, 8'h30};
        send_seq();
        expect_eq("tri_count", wx.size(), 195);
        expect_eq("tri_p0", {wx[0][15:0], wy[0][15:0]}, {16'd16, 16'd16});
        expect_eq("tri_e0_end", {wx[48][15:0], wy[48][15:0]}, {16'd64, 16'd32});
        expect_eq("tri_e1_start", {wx[49][15:0], wy[49][15:0]}, {16'd64, 16'd32});
        expect_eq("tri_e1_end", {wx[97][15:0], wy[97][15:0]}, {16'd112, 16'd48});
        expect_eq("tri_e2_start", {wx[98][15:0], wy[98][15:0]}, {16'd112, 16'd48});
        expect_eq("tri_e2_end", {wx[194][15:0], wy[194][15:0]}, {16'd16, 16'd16});
        expect_eq("tri_span", wc[194] - wc[0], 194);
        expect_eq("tri_irq_cyc", ic[0], wc[194] + 1);

        // Resync stream with empty frame
        clear_log();
        tx_q = '{8'h12, 8'h45, 8'h13, 8'h45, 8'h45, 8'h01, 8'h00};
        send_seq();
        expect_eq("sync_irq_early", ic.size(), 0);
        tx_q = '{8'h00};
        send_seq();
        expect_eq("sync_irq", ic.size(), 1);
        expect_eq("sync_slverr", n_slverr, 0);
        expect_eq("sync_writes", wx.size(), 0);

        // Unknown types and bad address, then a normal frame
        clear_log();
        tx_q = '{8'h45, 8'h45, 8'h01, 8'h00, 8'h01, 8'h05};
        send_seq();
        expect_eq("t05_resp", last_resp, 2);
        tx_q = '{8'h45, 8'h45, 8'h01, 8'h00, 8'h01, 8'h0E};
        send_seq();
        expect_eq("t0e_resp", last_resp, 2);
        send_byte(32'd2, 8'h45, 1'b1);
        expect_eq("badaddr_resp", last_resp, 2);
        expect_eq("bad_writes", wx.size(), 0);
        expect_eq("bad_irqs", ic.size(), 0);
        tx_q = '{8'h45, 8'h45, 8'h01, 8'h00, 8'h01, 8'h0A, 8'h20, 8'h21};
        send_seq();
        expect_eq("recover_resp", last_resp, 0);
        expect_eq("recover_count", wx.size(), 1);
        expect_eq("recover_pix", {wx[0][15:0], wy[0][15:0]}, {16'd32, 16'd33});
        expect_eq("recover_irq", ic.size(), 1);

        // Reset in the middle of a long line
        clear_log();
        tx_q = '{8'h45, 8'h45, 8'h01, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'hFF};
        foreach (tx_q[i]) send_byte(32'd1, tx_q[i], 1'b1);
        send_byte(32'd1, 8'h00, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        expect_eq("mid_drawing", 32'(Write), 1);
        reset = 1'b1;
        #1;
        expect_eq("mid_reset_ctrl", 32'({Write, iAWREADY, iWREADY, iBVALID}), 0);
        @(negedge clk) reset = 1'b0;
        clear_log();
        tx_q = '{8'h45, 8'h45, 8'h01, 8'h00, 8'h01, 8'h0A, 8'h05, 8'h05};
        send_seq();
        expect_eq("post_reset_count", wx.size(), 1);
        expect_eq("post_reset_pix", {wx[0][15:0], wy[0][15:0]}, {16'd5, 16'd5});
        expect_eq("post_reset_irq", ic.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/accelerator.md
# accelerator

Byte-stream 2-D vector rasterizer sitting between the control sequencer and the 640×480 1-bpp video memory. It accepts command bytes over an AXI4-Lite-style write-only slave, parses a frame of primitives, and emits one pixel write per clock (`xAddr`, `yAddr`, `Write`) for the frame-buffer address generator. It pulses `RenderEndInterrupt` when a frame is fully drawn.

## Interface
- `ADDR_WIDTH`, default 32: width of `iAWADDR`.
- `DATA_WIDTH`, default 8: width of `iWDATA`; only 8 is supported.
- `clk`  in  1: clock. Reset: `reset`, asynchronous, active-high.
- `reset`  in  1: async reset.
- `iAWADDR`  in  ADDR_WIDTH: write address; 1 = command port.
- `iAWPROT`  in  3: accepted, ignored.
- `iAWVALID` / `iAWREADY`  in/out  1: address handshake.
- `iWDATA`  in  8: command byte.
- `iWSTRB`  in  DATA_WIDTH/8: ignored.
- `iWVALID` / `iWREADY`  in/out  1: data handshake.
- `iBVALID` / `iBREADY`  out/in  1: response handshake.
- `iBRESP`  out  2: 2'b00 OKAY, 2'b10 SLVERR.
- `xAddr`, `yAddr`  out  16: pixel coordinate, valid when `Write` is high.
- `Write`  out  1: pixel strobe, one pixel per cycle.
- `RenderEndInterrupt`  out  1: one-cycle pulse at frame end.

## Operation
- Byte accept: when idle, `iBVALID`=0, `iAWVALID`=`iWVALID`=1 → assert `iAWREADY` and `iWREADY` together, registered, for one cycle. The byte is captured in the cycle both readies and both valids are high. `iBVALID` rises the next cycle and holds until `iBREADY`. No new byte is accepted while `iBVALID`=1 or while rasterizing.
- Address ≠ 1: byte discarded, SLVERR.
- Parser states: SYNC0, SYNC1, ZOOM, ANGLE, COUNT, TYPE, ARGS, DRAW.
  - SYNC0 expects 0x45, then SYNC1 expects 0x45. Any other byte returns to SYNC0 with OKAY.
  - ZOOM: zoom byte; 0 is treated as 1.
  - ANGLE: stored, reserved, no effect.
  - COUNT: object count N. N=0 → interrupt, then SYNC0.
- TYPE byte, low nibble selects the object:
  - 0x0: NOP padding, not counted.
  - 0x2: Line, 4 args (x0 y0 x1 y1).
  - 0x7: Triangle, 6 args; drawn as edges p0→p1, p1→p2, p2→p0.
  - 0xA: Dot, 2 args; one pixel.
  - Any other type: SLVERR, rest of frame dropped, return to SYNC0, no interrupt.
- Coordinates: `byte × zoom`, zero-extended to 16 bits; no clipping.
- Lines: Bresenham, both endpoints inclusive, max(|dx|,|dy|)+1 pixels, all octants. Shared triangle vertices are written twice.
- After the last object's last pixel: `RenderEndInterrupt` pulses 1 cycle, then SYNC0.

## Timing
- First `Write` is the cycle after the handshake of the final argument byte.
- Pixels are emitted back-to-back, including across triangle edges.
- `iBVALID` for the final argument byte is asserted only after the last pixel of that object.
- The interrupt fires the cycle after the last `Write` of the frame.
- Reset values: readies 0, `iBVALID` 0, `iBRESP` 0, `Write` 0, `xAddr`/`yAddr` 0, interrupt 0, zoom 1, angle 0, parser in SYNC0.
- Reset mid-draw: `Write` drops immediately and the partial object is discarded.

## Configuration
- `ACCEL_CIRCLE_EN` defined: type 0xE is a Circle with 3 args (cx cy r), rasterized by the midpoint algorithm with r scaled by zoom.
- `ACCEL_CIRCLE_EN` undefined: 0xE is an unknown type (SLVERR, frame dropped).

## Test plan
- Frame 45 45 01 00 02 | 02 30 40 70 60 | 00 | 0A 10 10 → Line gives 65 writes from (48,64) to (112,96); NOP is skipped; Dot writes (16,16); then 1 interrupt.
- Zoom 2, line 00 00 03 00 → 7 writes at (0,0)…(6,0), one per cycle, no gaps.
- Triangle 07 10 10 40 20 70 30 at zoom 1 → three edges with endpoints (16,16), (64,32), (112,48); interrupt after the last write.
- Stream 12 45 13 45 45 01 00 00 → interrupt only after the final 00; all responses OKAY.
- Type 0x05 → SLVERR, no writes, no interrupt; the next valid frame renders normally.
- Assert `reset` during a line → `Write`, readies and `iBVALID` are 0 on the next edge; the parser restarts in SYNC0.
